// File: rtl/draw_dispatch_pkg.sv
// Shared constants, object-entry field layout and sequencer state encoding
// for the draw pipeline (draw_dispatch and its address helper).
package draw_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int LINE_LEN = 10;
    localparam int FB_AW    = 19;
    localparam int COLOR_W  = 3;

    localparam int X_LSB     = 0;
    localparam int Y_LSB     = 10;
    localparam int VALID_BIT = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/draw_dispatch_if.sv
// Bundle of the object-table, draw-stage and frame-status signals of draw_dispatch.
// timeout_err exists only when DRAW_DISPATCH_TIMEOUT_EN is defined.
interface draw_dispatch_if
    import draw_pkg::*;
#(
    parameter int NUM_OBJ = 16
);
    localparam int SW = $clog2(NUM_OBJ);

    logic             frame_start;
    logic [SW-1:0]    obj_raddr;
    logic [19:0]      obj_rdata;
    logic [FB_AW-1:0] pixeladdress;
    logic             start_drawing;
    logic             finished_drawing;
    logic             busy;
    logic             frame_done;
    logic [SW:0]      drawn_count;
    logic             overrun;
`ifdef DRAW_DISPATCH_TIMEOUT_EN
    logic             timeout_err;

    modport master (
        input  frame_start, obj_rdata, finished_drawing,
        output obj_raddr, pixeladdress, start_drawing, busy, frame_done,
               drawn_count, overrun, timeout_err
    );
    modport slave (
        output frame_start, obj_rdata, finished_drawing,
        input  obj_raddr, pixeladdress, start_drawing, busy, frame_done,
               drawn_count, overrun, timeout_err
    );
`else
    modport master (
        input  frame_start, obj_rdata, finished_drawing,
        output obj_raddr, pixeladdress, start_drawing, busy, frame_done,
               drawn_count, overrun
    );
    modport slave (
        output frame_start, obj_rdata, finished_drawing,
        input  obj_raddr, pixeladdress, start_drawing, busy, frame_done,
               drawn_count, overrun
    );
`endif
endinterface

// File: rtl/draw_dispatch_xy_to_addr.sv
// Combinational (x,y) -> linear framebuffer address with clip flags.
// y*640 is formed as (y<<9)+(y<<7) so no multiplier is needed.
module xy_to_addr
    import draw_pkg::*;
(
    input  logic [9:0]       i_x,
    input  logic [8:0]       i_y,
    output logic [FB_AW-1:0] o_addr,
    output logic             o_x_oob,
    output logic             o_y_oob
);
    localparam logic [9:0] X_LIM = 10'(SCREEN_W);
    localparam logic [8:0] Y_MAX = 9'(SCREEN_H - LINE_LEN);

    assign o_addr  = FB_AW'({i_y, 9'b0}) + FB_AW'({i_y, 7'b0}) + FB_AW'(i_x);
    assign o_x_oob = (i_x >= X_LIM);
    // Clip so that a LINE_LEN-row line starting at y stays on screen.
    assign o_y_oob = (i_y > Y_MAX);
endmodule

// File: rtl/draw_dispatch.sv
// Per-frame walker of the object table issuing one draw command per visible slot.
// Optional draw timeout: define DRAW_DISPATCH_TIMEOUT_EN.
module draw_dispatch
    import draw_pkg::*;
#(
    parameter int NUM_OBJ = 16
`ifdef DRAW_DISPATCH_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input logic              clock,
    input logic              reset,
    draw_dispatch_if.master  bus
);
    localparam int SW = $clog2(NUM_OBJ);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_OBJ - 1);

    state_t           r_state;
    logic [SW-1:0]    r_slot;
    logic [SW:0]      r_count;
    logic [SW:0]      r_drawn_count;
    logic [FB_AW-1:0] r_pixaddr;
    logic             r_arm_cnt;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    logic             w_valid;
    logic [9:0]       w_x;
    logic [8:0]       w_y;
    logic [FB_AW-1:0] w_addr;
    logic             w_x_oob;
    logic             w_y_oob;

    assign w_valid = bus.obj_rdata[VALID_BIT];
    assign w_x     = bus.obj_rdata[Y_LSB-1:X_LSB];
    assign w_y     = bus.obj_rdata[VALID_BIT-1:Y_LSB];

    xy_to_addr u_xy (
        .i_x     (w_x),
        .i_y     (w_y),
        .o_addr  (w_addr),
        .o_x_oob (w_x_oob),
        .o_y_oob (w_y_oob)
    );

`ifdef DRAW_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;
    assign bus.timeout_err = r_timeout_err;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_slot        <= '0;
            r_count       <= '0;
            r_drawn_count <= '0;
            r_pixaddr     <= '0;
            r_arm_cnt     <= 1'b0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef DRAW_DISPATCH_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (bus.frame_start && r_busy)
                r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: if (bus.frame_start) begin
                    r_slot  <= '0;
                    r_busy  <= 1'b1;
                    r_count <= '0;
                    r_state <= ST_READ;
                end
                ST_READ: r_state <= ST_EVAL;
                ST_EVAL: if (w_valid && !w_x_oob && !w_y_oob) begin
                    r_pixaddr <= w_addr;
                    r_start   <= 1'b1;
                    r_state   <= ST_ISSUE;
                end else begin
                    r_state <= ST_NEXT;
                end
                ST_ISSUE: begin
                    r_start   <= 1'b0;
                    r_count   <= r_count + 1'b1;
                    r_arm_cnt <= 1'b0;
`ifdef DRAW_DISPATCH_TIMEOUT_EN
                    r_to_cnt  <= '0;
`endif
                    r_state   <= ST_ARM;
                end
                // finished_drawing may still show the previous idle level here.
                ST_ARM: begin
`ifdef DRAW_DISPATCH_TIMEOUT_EN
                    r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    if (!bus.finished_drawing)
                        r_state <= ST_WAIT;
                    else if (r_arm_cnt)
                        r_state <= ST_NEXT;
                    else
                        r_arm_cnt <= 1'b1;
                end
                ST_WAIT: begin
`ifdef DRAW_DISPATCH_TIMEOUT_EN
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (bus.finished_drawing) begin
                        r_state <= ST_NEXT;
                    end else if (r_to_cnt >= TO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_NEXT;
                    end
`else
                    if (bus.finished_drawing)
                        r_state <= ST_NEXT;
`endif
                end
                ST_NEXT: if (r_slot == LAST_SLOT) begin
                    r_state <= ST_DONE;
                end else begin
                    r_slot  <= r_slot + 1'b1;
                    r_state <= ST_READ;
                end
                ST_DONE: begin
                    r_done        <= 1'b1;
                    r_drawn_count <= r_count;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.obj_raddr     = r_slot;
    assign bus.pixeladdress  = r_pixaddr;
    assign bus.start_drawing = r_start;
    assign bus.busy          = r_busy;
    assign bus.frame_done    = r_done;
    assign bus.drawn_count   = r_drawn_count;
    assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_draw_dispatch.sv
// Directed bench for draw_dispatch: object table, draw-stage model and immediate-assertion checks.
// Adds a timeout scenario when DRAW_DISPATCH_TIMEOUT_EN is defined.
module tb_draw_dispatch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    draw_dispatch_if #(.NUM_OBJ(16)) bus ();

    draw_dispatch #(.NUM_OBJ(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [19:0] mem [16];
    logic [19:0] rdata_r = '0;
    always @(posedge clock) rdata_r <= mem[bus.obj_raddr];
    assign bus.obj_rdata = rdata_r;

    // Draw-stage model: samples start_drawing on the falling edge, busy for draw_len cycles.
    int   draw_len  = 10;
    logic stuck     = 1'b0;
    logic clr_stats = 1'b0;
    logic fin_r     = 1'b1;
    int   draw_cnt  = 0;
    int   n_starts  = 0;
    int   viol      = 0;
    int   last_pix  = 0;
    int   first_pix = 0;
    int   pix_sum   = 0;
    assign bus.finished_drawing = fin_r & ~stuck;

    always @(negedge clock) begin
        if (clr_stats) begin
            n_starts <= 0;
            viol     <= 0;
            pix_sum  <= 0;
        end else if (bus.start_drawing) begin
            if (draw_cnt != 0) viol <= viol + 1;
            if (n_starts == 0) first_pix <= int'(bus.pixeladdress);
            n_starts <= n_starts + 1;
            last_pix <= int'(bus.pixeladdress);
            pix_sum  <= pix_sum + int'(bus.pixeladdress);
        end
        if (bus.start_drawing) begin
            fin_r    <= 1'b0;
            draw_cnt <= draw_len;
        end else if (draw_cnt != 0) begin
            draw_cnt <= draw_cnt - 1;
            if (draw_cnt == 1) fin_r <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (bus.frame_done !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    int cyc;

    initial begin
        bus.frame_start = 1'b0;
        clear_mem();
        #2;
        check("reset_raddr", 32'(bus.obj_raddr), 0);
        check("reset_pix", 32'(bus.pixeladdress), 0);
        check("reset_start", 32'(bus.start_drawing), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.frame_done), 0);
        check("reset_drawn", 32'(bus.drawn_count), 0);
        check("reset_overrun", 32'(bus.overrun), 0);
        tick();
        reset = 1'b0;
        clear_stats();

        // Empty table.
        start_frame();
        check("empty_busy", 32'(bus.busy), 1);
        wait_done(500, cyc);
        $display("empty table: frame_done after %0d cycles, starts=%0d", cyc, n_starts);
        check("empty_latency", 32'(cyc), 49);
        check("empty_drawn", 32'(bus.drawn_count), 0);
        check("empty_starts", 32'(n_starts), 0);
        check("empty_busy_end", 32'(bus.busy), 0);
        tick();
        check("done_one_cycle", 32'(bus.frame_done), 0);

        // Single object in slot 3.
        mem[3] = {1'b1, 9'd100, 10'd200};
        clear_stats();
        start_frame();
        wait_done(2000, cyc);
        $display("slot3: cycles=%0d starts=%0d pix=%0d", cyc, n_starts, last_pix);
        check("slot3_seen_done", 32'(bus.frame_done), 1);
        check("slot3_starts", 32'(n_starts), 1);
        check("slot3_pix", 32'(last_pix), 64200);
        check("slot3_drawn", 32'(bus.drawn_count), 1);
        tick();
        check("slot3_pix_hold", 32'(bus.pixeladdress), 64200);

        // Clipping boundaries.
        clear_mem();
        mem[0] = {1'b1, 9'd0, 10'd640};
        mem[1] = {1'b1, 9'd471, 10'd0};
        mem[2] = {1'b1, 9'd470, 10'd639};
        mem[4] = {1'b0, 9'd10, 10'd10};
        clear_stats();
        start_frame();
        wait_done(2000, cyc);
        $display("clip: cycles=%0d starts=%0d pix=%0d", cyc, n_starts, last_pix);
        check("clip_starts", 32'(n_starts), 1);
        check("clip_pix", 32'(last_pix), 301439);
        check("clip_drawn", 32'(bus.drawn_count), 1);

        // Full table with an overlapping frame_start.
        for (int i = 0; i < 16; i++) mem[i] = {1'b1, 9'(i * 10), 10'(i * 3)};
        clear_stats();
        start_frame();
        repeat (20) tick();
        check("full_no_overrun_yet", 32'(bus.overrun), 0);
        start_frame();
        check("full_overrun", 32'(bus.overrun), 1);
        wait_done(5000, cyc);
        $display("full: cycles=%0d starts=%0d sum=%0d viol=%0d", cyc, n_starts, pix_sum, viol);
        check("full_starts", 32'(n_starts), 16);
        check("full_drawn", 32'(bus.drawn_count), 16);
        check("full_last_pix", 32'(last_pix), 96045);
        check("full_pix_sum", 32'(pix_sum), 768360);
        check("full_handshake_viol", 32'(viol), 0);
        repeat (100) tick();
        check("full_no_extra_walk", 32'(n_starts), 16);
        check("full_idle_busy", 32'(bus.busy), 0);

        // Reset during WAIT of slot 5.
        for (int i = 0; i < 16; i++) mem[i] = {1'b1, 9'(i + 1), 10'(i + 1)};
        draw_len = 30;
        clear_stats();
        start_frame();
        cyc = 0;
        while (n_starts < 6 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("rst_reached_slot5", 32'(n_starts), 6);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        $display("reset mid-walk: busy=%0d start=%0d pix=%0d", bus.busy, bus.start_drawing, bus.pixeladdress);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_pix", 32'(bus.pixeladdress), 0);
        check("rst_drawn", 32'(bus.drawn_count), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_raddr", 32'(bus.obj_raddr), 0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        draw_len = 2;
        clear_stats();
        start_frame();
        wait_done(5000, cyc);
        $display("restart: cycles=%0d starts=%0d first_pix=%0d", cyc, n_starts, first_pix);
        check("restart_first_pix", 32'(first_pix), 641);
        check("restart_starts", 32'(n_starts), 16);
        check("restart_drawn", 32'(bus.drawn_count), 16);

`ifdef DRAW_DISPATCH_TIMEOUT_EN
        clear_mem();
        mem[0] = {1'b1, 9'd1, 10'd0};
        mem[1] = {1'b1, 9'd2, 10'd0};
        tick();
        stuck = 1'b1;
        clear_stats();
        start_frame();
        wait_done(5000, cyc);
        $display("timeout: cycles=%0d starts=%0d err=%0d", cyc, n_starts, bus.timeout_err);
        check("to_err", 32'(bus.timeout_err), 1);
        check("to_starts", 32'(n_starts), 2);
        check("to_drawn", 32'(bus.drawn_count), 2);
        stuck = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_dispatch.md
Name: draw_dispatch

Overview:
- Per-frame sequencer directly upstream of the line-drawing stage (the block taking `pixeladdress`, `start_drawing` and `finished_drawing`).
- On each frame trigger it walks the object table (missile/target slots), converts each active slot's (x,y) into a linear framebuffer address, and issues one draw command per slot.
- Runs one command at a time, completing the start/finished handshake for each slot before moving to the next.

Parameters:
- NUM_OBJ, 16, number of object-table slots (power of 2, ≥2)
- SCREEN_W, 640, framebuffer row pitch in pixels
- SCREEN_H, 480, visible rows
- LINE_LEN, 10, rows drawn per object by the downstream stage; used for vertical clipping
- TIMEOUT, 64, cycles allowed for `finished_drawing` (optional feature only)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse; starts a table walk
- obj_raddr  out  $clog2(NUM_OBJ)  object-table read address
- obj_rdata  in  20  {valid[19], y[18:10] (9b), x[9:0] (10b)}; valid one cycle after `obj_raddr`
- pixeladdress  out  19  linear address y*SCREEN_W + x to the draw stage
- start_drawing  out  1  one-cycle command pulse to the draw stage
- finished_drawing  in  1  level; high when the draw stage is idle
- busy  out  1  high from accepted `frame_start` until `frame_done`
- frame_done  out  1  one-cycle pulse at end of walk
- drawn_count  out  $clog2(NUM_OBJ)+1  objects issued in the last completed frame
- overrun  out  1  sticky; set when `frame_start` arrives while busy

Behaviour:
- Reset values: obj_raddr=0, pixeladdress=0, start_drawing=0, busy=0, frame_done=0, drawn_count=0, overrun=0; state IDLE.
- States:
  - IDLE: on `frame_start`, set slot=0, `busy`=1, clear the internal count, go to READ.
  - READ: drive `obj_raddr`=slot; go to EVAL next cycle (1-cycle table latency).
  - EVAL: skip the slot if valid=0, or x ≥ SCREEN_W, or y > SCREEN_H−LINE_LEN (470). Otherwise latch `pixeladdress` = y*SCREEN_W + x (19-bit, computed as (y<<9)+(y<<7)+x; max 307199, no overflow) and go to ISSUE. A skipped slot goes to NEXT.
  - ISSUE: `start_drawing`=1 for exactly this cycle; increment the internal count; go to ARM.
  - ARM: the draw stage samples on the opposite clock edge, so `finished_drawing` may still be stale-high. Wait here until `finished_drawing`=0, then go to WAIT. If it is still 1 after 2 cycles, treat the command as completed and go to NEXT.
  - WAIT: hold until `finished_drawing`=1, then go to NEXT.
  - NEXT: if slot==NUM_OBJ−1, go to DONE; else slot+1, go to READ.
  - DONE: `frame_done`=1 for one cycle; `drawn_count`←internal count; `busy`=0; go to IDLE.
- `pixeladdress` stays stable from EVAL until the next EVAL that accepts a slot.
- Timing:
  - Per accepted slot: READ+EVAL+ISSUE+ARM+WAIT+NEXT, at least 6 cycles plus draw time.
  - Per skipped slot: 3 cycles.
  - Empty table: `frame_done` exactly 3*NUM_OBJ+1 cycles after `frame_start`.
- `frame_start` while busy: ignored for sequencing; sets `overrun`. `overrun` clears only on reset.
- `frame_start` in the same cycle as DONE: ignored and sets `overrun`, because `busy` is still 1.
- Reset mid-walk: everything returns immediately to reset values. `start_drawing` drops asynchronously; the downstream stage finishes its current line on its own.
- `drawn_count` is not updated on an aborted walk.

Optional Feature:
- Macro: DRAW_DISPATCH_TIMEOUT_EN.
- Enabled:
  - A counter runs in ARM/WAIT. If it reaches TIMEOUT without `finished_drawing`=1 in WAIT, the slot is abandoned, the FSM goes to NEXT, and sticky output `timeout_err` (1b, reset 0) is set.
  - The slot still counts in `drawn_count`.
- Disabled: no counter and no `timeout_err` port; WAIT waits indefinitely.

Decomposition:
- Shared package `draw_pkg`:
  - constants SCREEN_W, SCREEN_H, LINE_LEN, FB_AW=19, COLOR_W=3
  - object-entry field offsets (X_LSB=0, Y_LSB=10, VALID_BIT=19)
  - state enum typedef.
- One sub-module is natural: `xy_to_addr`, the combinational shift-add y*640+x with clip flags (x_oob, y_oob). Reused by future sprite/erase stages.

Test Plan:
- Reset then `frame_start` with all slots invalid → no `start_drawing`; `frame_done` at cycle 49 (NUM_OBJ=16); `drawn_count`=0.
- Slot 3 = {1, y=100, x=200}, draw-stage model takes 10 cycles → one `start_drawing` with `pixeladdress`=64200; `drawn_count`=1.
- Slot 0 x=640, slot 1 y=471, slot 2 y=470 x=639 → only slot 2 issued with `pixeladdress`=301439; `drawn_count`=1.
- All 16 slots valid → 16 start pulses, each issued only after `finished_drawing` rises again; second `frame_start` mid-walk → `overrun`=1, no extra walk.
- Assert reset during WAIT of slot 5 → outputs at reset values the same cycle; next `frame_start` restarts at slot 0.
- With DRAW_DISPATCH_TIMEOUT_EN and `finished_drawing` stuck 0 → slot abandoned after 64 cycles; `timeout_err`=1; walk continues to the next slot.
